// File: rtl/reg_file_pkg.sv
// Shared widths, word/address types and the write-address decoder for reg_file.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: none; consumers are the register file interface and top.
package reg_file_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // One-hot decode of a write address over R1..R31 only; address 0 decodes
   // to all zeros, which is what keeps R0 permanently unwritable.
   function automatic logic [NUM_REGS-1:1] decode_wr(input addr_t a);
      logic [NUM_REGS-1:1] res;
      res = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         res[i] = (a == addr_t'(i));
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// Read/write bus of the register file: two read ports and one write port.
// Latency: reads are combinational, writes land on the rising clock edge.
// Backpressure: none; every write with WrEn=1 is accepted on its edge.
interface reg_file_if;
   import reg_file_pkg::*;

   addr_t Ard1;
   addr_t Ard2;
   addr_t Awr;
   data_t Din;
   logic  WrEn;
   data_t Dout1;
   data_t Dout2;

   modport master (
      output Ard1, Ard2, Awr, Din, WrEn,
      input  Dout1, Dout2
   );

   modport slave (
      input  Ard1, Ard2, Awr, Din, WrEn,
      output Dout1, Dout2
   );

endinterface

// File: rtl/reg_file_reg32.sv
// Single 32-bit storage register with load enable and synchronous clear.
// Latency: D captured on the rising edge when WE=1; Q is the registered value.
// Backpressure: none; clear wins over load on the same edge.
module reg32
   import reg_file_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  i_we,
   input  data_t i_d,
   output data_t o_q
);

   data_t r_q;

   // Synchronous active-low clear has priority, so a write coinciding with reset is dropped.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_we) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, R0 hard-wired to zero, two combinational read ports.
// Latency: write visible on reads right after its edge; reads are zero-cycle.
// Backpressure: none. Define REG_FILE_BYPASS_EN to forward Din to a read
// port that addresses the register currently being written.
module reg_file
   import reg_file_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst_n,
   reg_file_if.slave bus
);

   logic [NUM_REGS-1:1] w_we;
   data_t               w_q [NUM_REGS];
   data_t               w_rd1;
   data_t               w_rd2;

   // Per-register write strobes; the decoder never selects R0.
   assign w_we = decode_wr(bus.Awr) & {(NUM_REGS-1){bus.WrEn}};

   // R0 is a constant rather than storage.
   assign w_q[0] = '0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
      reg32 u_reg (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_we    (w_we[g]),
         .i_d     (bus.Din),
         .o_q     (w_q[g])
      );
   end

   // Read port 1: 32:1 mux over stored values, optionally overridden by the in-flight write.
   always_comb begin
      w_rd1 = w_q[bus.Ard1];
`ifdef REG_FILE_BYPASS_EN
      if (bus.WrEn && (bus.Awr != '0) && (bus.Awr == bus.Ard1)) begin
         w_rd1 = bus.Din;
      end
`endif
   end

   // Read port 2: identical, independent mux.
   always_comb begin
      w_rd2 = w_q[bus.Ard2];
`ifdef REG_FILE_BYPASS_EN
      if (bus.WrEn && (bus.Awr != '0) && (bus.Awr == bus.Ard2)) begin
         w_rd2 = bus.Din;
      end
`endif
   end

   assign bus.Dout1 = w_rd1;
   assign bus.Dout2 = w_rd2;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios then randomized traffic.
// Latency: expects zero-cycle reads and writes visible right after their edge.
// Backpressure: none; honours REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file;
   import reg_file_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [31:0] mem [32];

   reg_file_if u_if ();

   reg_file u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected read value from the architectural state plus the current write request.
   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
      if (u_if.WrEn && (u_if.Awr == a)) return u_if.Din;
`endif
      return mem[a];
   endfunction

   // Advance one edge and apply the architectural effect of that edge to the model.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      end else if (u_if.WrEn && (u_if.Awr != 5'd0)) begin
         mem[u_if.Awr] = u_if.Din;
      end
      #1;
   endtask

   task automatic check_ports(input string tag);
      #1;
      check_val({tag, "_d1"}, u_if.Dout1, exp_read(u_if.Ard1));
      check_val({tag, "_d2"}, u_if.Dout2, exp_read(u_if.Ard2));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 32; i++) mem[i] = 32'hxxxx_xxxx;
      rst_n     = 1'b0;
      u_if.WrEn = 1'b1;
      u_if.Awr  = 5'd5;
      u_if.Din  = $urandom;
      u_if.Ard1 = 5'd0;
      u_if.Ard2 = 5'd0;

      // Reset, then every address reads zero on both ports.
      tick();
      rst_n     = 1'b1;
      u_if.WrEn = 1'b0;
      for (int a = 0; a < 32; a++) begin
         u_if.Ard1 = 5'(a);
         u_if.Ard2 = 5'(31 - a);
         #1;
         check_val("rst_d1", u_if.Dout1, 32'd0);
         check_val("rst_d2", u_if.Dout2, 32'd0);
      end

      // Disabled write leaves R3 alone; enabled write lands.
      u_if.WrEn = 1'b0; u_if.Awr = 5'd3; u_if.Din = 32'd32; u_if.Ard2 = 5'd3;
      tick();
      #1 check_val("we0_r3", u_if.Dout2, 32'd0);
      u_if.WrEn = 1'b1;
      tick();
      u_if.WrEn = 1'b0;
      #1 check_val("we1_r3", u_if.Dout2, 32'd32);
      u_if.Ard1 = 5'd10;
      #1 check_val("r10_clr", u_if.Dout1, 32'd0);

      // Second register, cross-port readback.
      u_if.WrEn = 1'b1; u_if.Awr = 5'd10; u_if.Din = 32'd2;
      tick();
      u_if.WrEn = 1'b0; u_if.Ard2 = 5'd10;
      #1 check_val("r10", u_if.Dout2, 32'd2);
      u_if.Ard1 = 5'd3;
      #1 check_val("r3_keep", u_if.Dout1, 32'd32);

      // Writes to R0 are ignored.
      u_if.WrEn = 1'b1; u_if.Awr = 5'd0; u_if.Din = 32'd9;
      tick();
      u_if.Din = 32'd2;
      tick();
      tick();
      u_if.WrEn = 1'b0; u_if.Ard1 = 5'd0;
      #1 check_val("r0_zero", u_if.Dout1, 32'd0);

      // Reset beats a simultaneous write; first cycle after reset accepts writes.
      u_if.WrEn = 1'b1; u_if.Awr = 5'd5; u_if.Din = 32'hDEADBEEF; rst_n = 1'b0;
      tick();
      rst_n = 1'b1; u_if.WrEn = 1'b0; u_if.Ard1 = 5'd5; u_if.Ard2 = 5'd3;
      #1 check_val("rst_pri_r5", u_if.Dout1, 32'd0);
      check_val("rst_pri_r3", u_if.Dout2, 32'd0);
      u_if.WrEn = 1'b1;
      tick();
      u_if.WrEn = 1'b0;
      #1 check_val("post_rst_wr", u_if.Dout1, 32'hDEADBEEF);

      // Read of the register being written: before the edge, then after.
      u_if.Ard1 = 5'd7; u_if.Ard2 = 5'd7; u_if.Awr = 5'd7; u_if.Din = 32'h55; u_if.WrEn = 1'b1;
      #1;
`ifdef REG_FILE_BYPASS_EN
      check_val("same_pre_d1", u_if.Dout1, 32'h55);
      check_val("same_pre_d2", u_if.Dout2, 32'h55);
`else
      check_val("same_pre_d1", u_if.Dout1, 32'd0);
      check_val("same_pre_d2", u_if.Dout2, 32'd0);
`endif
      tick();
      u_if.WrEn = 1'b0;
      #1 check_val("same_post_d1", u_if.Dout1, 32'h55);
      check_val("same_post_d2", u_if.Dout2, 32'h55);

      // Randomized traffic against the array model.
      for (int it = 0; it < 600; it++) begin
         rst_n     = ($urandom_range(0, 40) != 0);
         u_if.WrEn = $urandom_range(0, 3) != 0;
         u_if.Awr  = 5'($urandom_range(0, 31));
         u_if.Din  = $urandom;
         u_if.Ard1 = ($urandom_range(0, 3) == 0) ? u_if.Awr : 5'($urandom_range(0, 31));
         u_if.Ard2 = ($urandom_range(0, 3) == 0) ? u_if.Awr : 5'($urandom_range(0, 31));
         check_ports("rnd_pre");
         tick();
         check_ports("rnd_post");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameters: none; widths fixed by package constants (data 32 bits, address 5 bits, 32 registers).
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 Clk  input  1  clock; all state changes on rising edge.
REQ-004 Rst_n  input  1  synchronous active-low reset.
REQ-005 Ard1  input  5  read address, port 1.
REQ-006 Ard2  input  5  read address, port 2.
REQ-007 Awr  input  5  write address.
REQ-008 Din  input  32  write data.
REQ-009 WrEn  input  1  write enable, active high.
REQ-010 Dout1  output  32  contents of register Ard1.
REQ-011 Dout2  output  32  contents of register Ard2.

Function
REQ-012 Storage SHALL be 32 registers x 32 bits, R0..R31.
REQ-013 R0 SHALL always read 0; writes to Awr=0 SHALL be ignored, regardless of Din and WrEn.
REQ-014 On a rising Clk with Rst_n=1 and WrEn=1, R[Awr] SHALL load Din (Awr 1..31).
REQ-015 With WrEn=0, no register SHALL change.
REQ-016 Dout1/Dout2 SHALL be combinational: a change on Ard1/Ard2 SHALL be reflected with zero cycle latency.
REQ-017 A newly written value SHALL appear on a read port addressing it immediately after the write edge; no earlier (see REQ-024 for forwarding).
REQ-018 Both read ports SHALL be independent; both may address the same register, including the one being written.
REQ-019 Write decode SHALL be a 5-to-32 one-hot decoder ANDed with WrEn to form per-register write enables; enable for R0 is forced 0.
REQ-020 Dout1/Dout2 SHALL never be X after the first reset edge.

Reset
REQ-021 On a rising Clk with Rst_n=0, R1..R31 SHALL clear to 0; Dout1/Dout2 therefore read 0 in the same cycle after the edge.
REQ-022 Reset SHALL take priority over a simultaneous write; the write is lost.
REQ-023 Deassertion SHALL require no extra cycle; a write in the first cycle with Rst_n=1 SHALL take effect.

Configuration
REQ-024 Macro REG_FILE_BYPASS_EN: when defined, a read port whose address equals Awr (nonzero) while WrEn=1 SHALL output Din combinationally (write-to-read forwarding); when undefined, it SHALL output the stored (old) value until the write edge.

Structure
REQ-025 Shared package reg_file_pkg SHALL hold DATA_W=32, ADDR_W=5, NUM_REGS=32 and typedefs for data word and address.
REQ-026 One sub-module reg32: 32-bit register with Clk, Rst_n, WE, D, Q; reg_file instantiates 31 of them (R1..R31), R0 is constant 0.
REQ-027 Read paths SHALL be two 32:1 multiplexers in reg_file.

Verification
REQ-028 Reset, then any Ard1/Ard2 -> Dout1=Dout2=0.
REQ-029 WrEn=0, Awr=3, Din=32, Ard2=3, one edge -> Dout2=0; then WrEn=1, one edge -> Dout2=32, Ard1=10 -> Dout1=0.
REQ-030 WrEn=1, Awr=10, Din=2, edge; Ard2=10 -> Dout2=2; Ard1=3 -> Dout1=32.
REQ-031 WrEn=1, Awr=0, Din=9 then Din=2, several edges; Ard1=0 -> Dout1=0.
REQ-032 WrEn=1, Awr=5, Din=0xDEADBEEF, Rst_n=0 same edge -> R5 reads 0; repeat with Rst_n=1 -> R5 reads 0xDEADBEEF.
REQ-033 Ard1=Ard2=Awr=7, WrEn=1, Din=0x55 before edge -> outputs old value (0) without REG_FILE_BYPASS_EN, 0x55 with it; both 0x55 after edge.
